// File: rtl/des_pkg.sv
// Shared DES constants: block geometry, FSM encodings and the IP / inverse-IP tables.
// Table entries use DES numbering, where bit 1 is the MSB of the 64-bit block.
package des_pkg;

   localparam int BLOCK_W = 64;
   localparam int HALF_W  = 32;

   typedef logic [1:BLOCK_W] des_block_t;

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_PERM = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // Output bit i (1-based) takes input bit IP_TABLE[i-1].
   localparam int IP_TABLE [BLOCK_W] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
   };

   // Final permutation used by the output stage of the core.
   localparam int INV_IP_TABLE [BLOCK_W] = '{
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
   };

endpackage

// File: rtl/des_ip_front_if.sv
// Byte-stream input and L0/R0 output handshakes of the DES front end.
// The slave modport is the DES front end; the master is its environment.
interface des_ip_front_if;
   import des_pkg::*;

   logic [7:0]        in_byte;
   logic              in_valid;
   logic              in_ready;
   logic [1:HALF_W]   L0;
   logic [1:HALF_W]   R0;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_byte, in_valid, out_ready,
      input  in_ready, L0, R0, out_valid
   );

   modport slave (
      input  in_byte, in_valid, out_ready,
      output in_ready, L0, R0, out_valid
   );

endinterface

// File: rtl/des_ip_perm.sv
// Purely combinational DES initial permutation, wired straight from the package table.
module des_ip_perm
   import des_pkg::*;
(
   input  des_block_t din,
   output des_block_t dout
);

   for (genvar i = 1; i <= BLOCK_W; i++) begin : g_bit
      assign dout[i] = din[IP_TABLE[i-1]];
   end

endmodule

// File: rtl/des_ip_front.sv
// DES front end: byte-serial block assembly, initial permutation and L0/R0 handoff.
// Optional DES_IP_PARALLEL_LOAD_EN adds a 64-bit parallel load path (par_in/par_valid).
//
// state   | meaning
// LOAD    | accepting bytes (or a parallel block) into the assembly register
// PERM    | one cycle: register IP(assembly) into L0/R0
// HOLD    | L0/R0 presented, waiting for out_ready
module des_ip_front
   import des_pkg::*;
#(
   parameter bit FIRST_BYTE_MSB    = 1'b1,
   parameter bit FLUSH_CLEARS_DATA = 1'b0
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
`ifdef DES_IP_PARALLEL_LOAD_EN
   input  logic [1:BLOCK_W] par_in,
   input  logic            par_valid,
`endif
   output logic            busy,
   des_ip_front_if.slave   bus
);

   logic [1:0]  state;
   logic [2:0]  byte_cnt;
   logic [2:0]  slot;
   des_block_t  asm_q;
   des_block_t  asm_nxt;
   des_block_t  perm_out;
   des_block_t  out_q;
   logic        par_take;
   logic        byte_take;

`ifdef DES_IP_PARALLEL_LOAD_EN
   assign par_take = (state == ST_LOAD) && (byte_cnt == 3'd0) && par_valid;
`else
   assign par_take = 1'b0;
`endif

   // A parallel load in the same cycle swallows the byte strobe.
   assign byte_take = (state == ST_LOAD) && bus.in_valid && !par_take;
   assign slot      = FIRST_BYTE_MSB ? byte_cnt : (3'd7 - byte_cnt);

   always_comb begin
      asm_nxt = asm_q;
      for (int k = 0; k < 8; k++) begin
         if (slot == k[2:0]) asm_nxt[8*k+1 +: 8] = bus.in_byte;
      end
   end

   des_ip_perm u_perm (
      .din  (asm_q),
      .dout (perm_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_LOAD;
         byte_cnt <= 3'd0;
         asm_q    <= '0;
         out_q    <= '0;
      end else if (flush) begin
         // L0/R0 deliberately keep their last value across a flush.
         state    <= ST_LOAD;
         byte_cnt <= 3'd0;
         if (FLUSH_CLEARS_DATA) asm_q <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
`ifdef DES_IP_PARALLEL_LOAD_EN
               if (par_take) begin
                  asm_q <= par_in;
                  state <= ST_PERM;
               end else
`endif
               if (byte_take) begin
                  asm_q    <= asm_nxt;
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt == 3'd7) state <= ST_PERM;
               end
            end
            ST_PERM: begin
               out_q <= perm_out;
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (bus.out_ready) state <= ST_LOAD;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_LOAD);
   assign bus.out_valid = (state == ST_HOLD);
   assign bus.L0        = out_q[1:HALF_W];
   assign bus.R0        = out_q[HALF_W+1:BLOCK_W];
   assign busy          = (state != ST_LOAD) || (byte_cnt != 3'd0);

endmodule
